// File: rtl/e1000_rx_pkg.sv
// Shared constants, FSM state types and ring-pointer helpers for the E1000 receive descriptor engine.
package e1000_rx_pkg;

  localparam int DESC_SIZE = 16;
  localparam int STAT_DD   = 0;
  localparam int STAT_EOP  = 1;

  localparam logic [1:0] RDMTS_HALF    = 2'd0;
  localparam logic [1:0] RDMTS_QUARTER = 2'd1;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DATA = 2'd2
  } fetch_state_e;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_BUSY = 1'b1
  } wb_state_e;

  // (a + b) mod n, for a < n and b <= n
  function automatic logic [15:0] ring_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) begin
      s = s - {1'b0, n};
    end else begin
      s = s;
    end
    return s[15:0];
  endfunction

  // (a - b) mod n, for a < n and b < n
  function automatic logic [15:0] ring_sub(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] n);
    logic [16:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, a} + {1'b0, n} - {1'b0, b};
    end
    return d[15:0];
  endfunction

  function automatic logic [15:0] rdmt_thresh(input logic [15:0] n, input logic [1:0] sel);
    logic [15:0] t;
    case (sel)
      RDMTS_HALF:    t = n >> 1;
      RDMTS_QUARTER: t = n >> 2;
      default:       t = n >> 3;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rx_desc_fifo.sv
// Synchronous FIFO holding prefetched receive buffer addresses; i_flush empties it in one cycle.
module rx_desc_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_aresetn,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && (r_count != CNT_MAX);
  assign w_pop_ok  = i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/e1000_rx_desc_ctrl.sv
// E1000 receive descriptor engine: ring prefetch, buffer hand-out, status write-back, RXT0/RXDMT0.
// Optional build macro: E1000_RXDMT_EN enables the RXDMT0 low-threshold interrupt.
module e1000_rx_desc_ctrl
  import e1000_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         en,
  input  logic [63:0]  rdba,
  input  logic [19:0]  rdlen,
  input  logic [15:0]  rdt,
  input  logic         rdh_wr,
  input  logic [15:0]  rdh_wdata,
  input  logic [1:0]   rdmts,
  output logic [15:0]  rdh,
  output logic         fetch_req,
  output logic [63:0]  fetch_addr,
  output logic [5:0]   fetch_cnt,
  input  logic         fetch_ack,
  input  logic         fd_valid,
  input  logic [127:0] fd_data,
  output logic         buf_valid,
  output logic [63:0]  buf_addr,
  input  logic         buf_ready,
  input  logic         cpl_valid,
  input  logic [15:0]  cpl_len,
  input  logic         cpl_eop,
  output logic         cpl_ready,
  output logic         wb_valid,
  output logic [63:0]  wb_addr,
  output logic [63:0]  wb_data,
  input  logic         wb_ready,
  output logic         intr_rxt0,
  output logic         intr_rxdmt0
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e r_fstate, w_fstate_nxt;
  wb_state_e    r_wstate, w_wstate_nxt;
  logic [15:0]  r_fptr, r_head, r_out_cnt, w_out_nxt;
  logic [5:0]   r_fetch_cnt, r_beat_cnt;
  logic [63:0]  r_fetch_addr, r_wb_addr, r_wb_data;
  logic         r_fetch_req, r_discard, r_cpl_ready, r_wb_valid, r_wb_eop, r_intr_rxt0;
  logic [15:0]  w_n, w_unfetched, w_free, w_to_end, w_min_a, w_min;
  logic         w_fetch_go, w_last_beat, w_push, w_pop, w_cpl_acc, w_wb_hs, w_empty;
  logic [63:0]  w_fifo_data;
  logic [CW-1:0] w_fifo_count;
  logic [7:0]   w_status;
  logic         w_unused;

  assign w_n         = rdlen[19:4];
  assign w_unfetched = ring_sub(rdt, r_fptr, w_n);
  assign w_free      = 16'(FIFO_DEPTH) - 16'(w_fifo_count);
  assign w_to_end    = w_n - r_fptr;
  assign w_min_a     = (w_unfetched < w_free) ? w_unfetched : w_free;
  assign w_min       = (w_min_a < w_to_end) ? w_min_a : w_to_end;
  assign w_last_beat = ((r_beat_cnt + 6'd1) == r_fetch_cnt);
  assign w_push      = (r_fstate == FETCH_DATA) && fd_valid && en && !r_discard;
  assign buf_valid   = !w_empty;
  assign w_pop       = buf_ready && !w_empty;
  assign w_cpl_acc   = cpl_valid && r_cpl_ready;
  assign w_wb_hs     = r_wb_valid && wb_ready;
  assign w_out_nxt   = r_out_cnt + {15'h0, w_pop} - {15'h0, w_cpl_acc};

  rx_desc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
    .i_clk     (aclk),
    .i_aresetn (aresetn),
    .i_flush   (!en),
    .i_push    (w_push),
    .i_wr_data (fd_data[63:0]),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_empty   (w_empty),
    .o_count   (w_fifo_count)
  );

  // Fetch FSM next state; a burst is launched only when ring, FIFO and enable all allow it
  always_comb begin
    w_fstate_nxt = r_fstate;
    w_fetch_go   = 1'b0;
    case (r_fstate)
      FETCH_IDLE: begin
        if (en && (w_n != 16'h0) && (w_unfetched != 16'h0) && (w_free != 16'h0)) begin
          w_fstate_nxt = FETCH_REQ;
          w_fetch_go   = 1'b1;
        end else begin
          w_fstate_nxt = FETCH_IDLE;
        end
      end
      FETCH_REQ: begin
        if (fetch_ack) w_fstate_nxt = FETCH_DATA;
        else           w_fstate_nxt = FETCH_REQ;
      end
      FETCH_DATA: begin
        if (fd_valid && w_last_beat) w_fstate_nxt = FETCH_IDLE;
        else                         w_fstate_nxt = FETCH_DATA;
      end
      default: w_fstate_nxt = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_fstate     <= FETCH_IDLE;
      r_fetch_req  <= 1'b0;
      r_fetch_cnt  <= 6'h0;
      r_fetch_addr <= 64'h0;
      r_beat_cnt   <= 6'h0;
      r_discard    <= 1'b0;
    end else begin
      r_fstate    <= w_fstate_nxt;
      r_fetch_req <= (w_fstate_nxt == FETCH_REQ);
      if (w_fetch_go) begin
        r_fetch_cnt  <= w_min[5:0];
        r_fetch_addr <= rdba + 64'(r_fptr) * 64'(DESC_SIZE);
        r_beat_cnt   <= 6'h0;
      end else if ((r_fstate == FETCH_DATA) && fd_valid) begin
        r_beat_cnt <= r_beat_cnt + 6'd1;
      end
      // A burst already requested must still be received after disable, but its beats are dropped
      if (r_fstate == FETCH_IDLE) r_discard <= 1'b0;
      else if (!en)               r_discard <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                            r_fptr <= 16'h0;
    else if (!en && rdh_wr)                  r_fptr <= rdh_wdata;
    else if (!en && r_fstate == FETCH_IDLE)  r_fptr <= r_head;
    else if (w_push && w_last_beat)          r_fptr <= ring_add(r_fptr, {10'h0, r_fetch_cnt}, w_n);
  end

  // Write-back FSM next state and descriptor status byte
  always_comb begin
    w_wstate_nxt       = r_wstate;
    w_status           = 8'h00;
    w_status[STAT_DD]  = 1'b1;
    w_status[STAT_EOP] = cpl_eop;
    case (r_wstate)
      WB_IDLE: begin
        if (w_cpl_acc) w_wstate_nxt = WB_BUSY;
        else           w_wstate_nxt = WB_IDLE;
      end
      WB_BUSY: begin
        if (wb_ready) w_wstate_nxt = WB_IDLE;
        else          w_wstate_nxt = WB_BUSY;
      end
      default: w_wstate_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate    <= WB_IDLE;
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= 64'h0;
      r_wb_data   <= 64'h0;
      r_wb_eop    <= 1'b0;
      r_head      <= 16'h0;
      r_out_cnt   <= 16'h0;
      r_cpl_ready <= 1'b0;
      r_intr_rxt0 <= 1'b0;
    end else begin
      r_wstate    <= w_wstate_nxt;
      r_wb_valid  <= (w_wstate_nxt == WB_BUSY);
      r_out_cnt   <= w_out_nxt;
      r_cpl_ready <= (w_wstate_nxt == WB_IDLE) && (w_out_nxt != 16'h0);
      r_intr_rxt0 <= w_wb_hs && r_wb_eop;
      if (w_cpl_acc) begin
        r_wb_addr <= rdba + 64'(r_head) * 64'(DESC_SIZE) + 64'd8;
        r_wb_data <= {16'h0, 8'h0, w_status, 16'h0, cpl_len};
        r_wb_eop  <= cpl_eop;
      end
      if (!en && rdh_wr) r_head <= rdh_wdata;
      else if (w_wb_hs)  r_head <= ring_add(r_head, 16'd1, w_n);
    end
  end

`ifdef E1000_RXDMT_EN
  logic [15:0] w_owned, w_thresh, r_owned_prev;
  logic        r_intr_rxdmt0;

  assign w_owned  = ring_sub(rdt, r_head, w_n);
  assign w_thresh = rdmt_thresh(w_n, rdmts);

  // Pulse only on the falling crossing of the threshold
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_owned_prev  <= 16'h0;
      r_intr_rxdmt0 <= 1'b0;
    end else begin
      r_owned_prev  <= w_owned;
      r_intr_rxdmt0 <= (r_owned_prev >= w_thresh) && (w_owned < w_thresh);
    end
  end

  assign intr_rxdmt0 = r_intr_rxdmt0;
`else
  logic w_unused_rdmts;
  assign w_unused_rdmts = ^rdmts;
  assign intr_rxdmt0    = 1'b0;
`endif

  always_comb begin
    if (!w_empty) buf_addr = w_fifo_data;
    else          buf_addr = 64'h0;
  end

  assign w_unused   = ^{fd_data[127:64], rdlen[3:0], w_min[15:6]};
  assign rdh        = r_head;
  assign fetch_req  = r_fetch_req;
  assign fetch_addr = r_fetch_addr;
  assign fetch_cnt  = r_fetch_cnt;
  assign cpl_ready  = r_cpl_ready;
  assign wb_valid   = r_wb_valid;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign intr_rxt0  = r_intr_rxt0;

endmodule

// File: tb/tb_e1000_rx_desc_ctrl.sv
// Directed self-checking bench for e1000_rx_desc_ctrl (ring fetch, wrap, write-back, RXDMT0, disable, reset).
module tb_e1000_rx_desc_ctrl;

  logic         aclk = 1'b0;
  logic         aresetn, en, rdh_wr, fetch_ack, fd_valid, buf_ready, cpl_valid, cpl_eop, wb_ready;
  logic [63:0]  rdba;
  logic [19:0]  rdlen;
  logic [15:0]  rdt, rdh_wdata, cpl_len, rdh;
  logic [1:0]   rdmts;
  logic         fetch_req, buf_valid, cpl_ready, wb_valid, intr_rxt0, intr_rxdmt0;
  logic [63:0]  fetch_addr, buf_addr, wb_addr, wb_data;
  logic [5:0]   fetch_cnt;
  logic [127:0] fd_data;

  int checks = 0;
  int errors = 0;
  int dmt_cnt = 0;
  int dmt_base;
  int dmt_exp;

  localparam logic [63:0] BASE = 64'h0000_0001_2340_0000;

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (intr_rxdmt0 === 1'b1) dmt_cnt++;
  end

  e1000_rx_desc_ctrl #(.FIFO_DEPTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .en(en), .rdba(rdba), .rdlen(rdlen), .rdt(rdt),
    .rdh_wr(rdh_wr), .rdh_wdata(rdh_wdata), .rdmts(rdmts), .rdh(rdh),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_cnt(fetch_cnt), .fetch_ack(fetch_ack),
    .fd_valid(fd_valid), .fd_data(fd_data), .buf_valid(buf_valid), .buf_addr(buf_addr),
    .buf_ready(buf_ready), .cpl_valid(cpl_valid), .cpl_len(cpl_len), .cpl_eop(cpl_eop),
    .cpl_ready(cpl_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready), .intr_rxt0(intr_rxt0), .intr_rxdmt0(intr_rxdmt0)
  );

  function automatic logic [63:0] desc_buf(input int idx);
    return 64'hB0F0_0000_0000_0000 + 64'(idx) * 64'h0000_0000_0000_0800;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_fetch(input string tag, input logic [63:0] exp_addr, input logic [5:0] exp_cnt);
    for (int i = 0; i < 50; i++) begin
      if (fetch_req === 1'b1) break;
      step(1);
    end
    chk({tag, "_req"}, {63'h0, fetch_req}, 64'd1);
    chk({tag, "_addr"}, fetch_addr, exp_addr);
    chk({tag, "_cnt"}, {58'h0, fetch_cnt}, {58'h0, exp_cnt});
    fetch_ack = 1'b1;
    step(1);
    fetch_ack = 1'b0;
    chk({tag, "_req_drop"}, {63'h0, fetch_req}, 64'd0);
  endtask

  task automatic send_beats(input int first_idx, input int n, input int ring_n);
    for (int k = 0; k < n; k++) begin
      fd_valid = 1'b1;
      fd_data  = {64'hDEAD_BEEF_DEAD_BEEF, desc_buf((first_idx + k) % ring_n)};
      step(1);
    end
    fd_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [63:0] exp_addr);
    for (int i = 0; i < 20; i++) begin
      if (buf_valid === 1'b1) break;
      step(1);
    end
    chk({tag, "_valid"}, {63'h0, buf_valid}, 64'd1);
    chk({tag, "_addr"}, buf_addr, exp_addr);
    buf_ready = 1'b1;
    step(1);
    buf_ready = 1'b0;
  endtask

  task automatic do_cpl(input string tag, input logic [15:0] len, input logic eop,
                        input logic [63:0] exp_addr, input logic [63:0] exp_data,
                        input logic [15:0] exp_head);
    for (int i = 0; i < 20; i++) begin
      if (cpl_ready === 1'b1) break;
      step(1);
    end
    chk({tag, "_cpl_ready"}, {63'h0, cpl_ready}, 64'd1);
    cpl_valid = 1'b1;
    cpl_len   = len;
    cpl_eop   = eop;
    step(1);
    cpl_valid = 1'b0;
    chk({tag, "_wb_valid"}, {63'h0, wb_valid}, 64'd1);
    chk({tag, "_wb_addr"}, wb_addr, exp_addr);
    chk({tag, "_wb_data"}, wb_data, exp_data);
    chk({tag, "_cpl_busy"}, {63'h0, cpl_ready}, 64'd0);
    wb_ready = 1'b1;
    step(1);
    wb_ready = 1'b0;
    chk({tag, "_rdh"}, {48'h0, rdh}, {48'h0, exp_head});
    chk({tag, "_rxt0"}, {63'h0, intr_rxt0}, {63'h0, eop});
  endtask

  initial begin
    aresetn = 1'b0; en = 1'b0; rdh_wr = 1'b0; rdh_wdata = 16'h0; fetch_ack = 1'b0;
    fd_valid = 1'b0; fd_data = 128'h0; buf_ready = 1'b0; cpl_valid = 1'b0; cpl_eop = 1'b0;
    cpl_len = 16'h0; wb_ready = 1'b0; rdba = 64'h0; rdlen = 20'h0; rdt = 16'h0; rdmts = 2'd0;
    step(3);
    aresetn = 1'b1;
    step(1);
    chk("rst_rdh", {48'h0, rdh}, 64'd0);
    chk("rst_ctl", {58'h0, fetch_req, buf_valid, cpl_ready, wb_valid, intr_rxt0, intr_rxdmt0}, 64'd0);

    // N=8, head=0, rdt=3: one burst of three
    rdba = BASE; rdlen = 20'h00080; rdt = 16'd3; en = 1'b1;
    wait_fetch("f1", BASE, 6'd3);
    chk("f1_empty", {63'h0, buf_valid}, 64'd0);
    send_beats(0, 1, 8);
    chk("f1_bufv_rise", {63'h0, buf_valid}, 64'd1);
    send_beats(1, 2, 8);
    pop("p0", desc_buf(0));
    pop("p1", desc_buf(1));
    pop("p2", desc_buf(2));
    step(3);
    chk("f1_no_refetch", {63'h0, fetch_req}, 64'd0);

    do_cpl("c0", 16'd64, 1'b0, BASE + 64'h08, 64'h0000_0001_0000_0040, 16'd1);
    do_cpl("c1", 16'd60, 1'b1, BASE + 64'h18, 64'h0000_0003_0000_003C, 16'd2);
    step(1);
    chk("c1_rxt0_single", {63'h0, intr_rxt0}, 64'd0);
    do_cpl("c2", 16'd100, 1'b1, BASE + 64'h28, 64'h0000_0003_0000_0064, 16'd3);

    // Wrap: fptr=6, rdt=2 -> two bursts of two
    en = 1'b0;
    step(2);
    rdh_wr = 1'b1; rdh_wdata = 16'd6;
    step(1);
    rdh_wr = 1'b0;
    chk("wrap_rdh", {48'h0, rdh}, 64'd6);
    rdt = 16'd2; en = 1'b1;
    wait_fetch("w1", BASE + 64'h60, 6'd2);
    send_beats(6, 2, 8);
    wait_fetch("w2", BASE, 6'd2);
    send_beats(0, 2, 8);
    for (int k = 0; k < 4; k++) pop("wp", desc_buf((6 + k) % 8));
    for (int k = 0; k < 4; k++) begin
      do_cpl("wc", 16'(100 + k), 1'b1, BASE + 64'((6 + k) % 8) * 64'd16 + 64'd8,
             {16'h0, 8'h0, 8'h03, 16'h0, 16'(100 + k)}, 16'((7 + k) % 8));
    end

    // N=16, rdmts=0: NIC-owned 9 -> 8 -> 7
    en = 1'b0;
    rdlen = 20'h00100;
    step(1);
    rdh_wr = 1'b1; rdh_wdata = 16'd0;
    step(1);
    rdh_wr = 1'b0;
    rdt = 16'd9; en = 1'b1;
    step(1);
    dmt_base = dmt_cnt;
    wait_fetch("d1", BASE, 6'd8);
    send_beats(0, 8, 16);
    pop("dp0", desc_buf(0));
    pop("dp1", desc_buf(1));
    do_cpl("dc0", 16'd10, 1'b0, BASE + 64'h08, 64'h0000_0001_0000_000A, 16'd1);
    step(3);
    chk("dmt_at_8", 64'(dmt_cnt - dmt_base), 64'd0);
    do_cpl("dc1", 16'd11, 1'b0, BASE + 64'h18, 64'h0000_0001_0000_000B, 16'd2);
    step(3);
`ifdef E1000_RXDMT_EN
    dmt_exp = 1;
`else
    dmt_exp = 0;
`endif
    chk("dmt_at_7", 64'(dmt_cnt - dmt_base), 64'(dmt_exp));

    // Reset while a write-back is outstanding
    pop("rp", desc_buf(2));
    cpl_valid = 1'b1; cpl_len = 16'd1; cpl_eop = 1'b1;
    step(1);
    cpl_valid = 1'b0;
    chk("rst_pre_wb", {63'h0, wb_valid}, 64'd1);
    aresetn = 1'b0;
    #1;
    chk("rst_async_rdh", {48'h0, rdh}, 64'd0);
    chk("rst_async_ctl", {58'h0, fetch_req, buf_valid, cpl_ready, wb_valid, intr_rxt0, intr_rxdmt0}, 64'd0);
    chk("rst_async_addr", fetch_addr | wb_addr | wb_data | buf_addr | {58'h0, fetch_cnt}, 64'd0);
    rdt = 16'd4;
    step(2);
    aresetn = 1'b1;

    // First fetch after reset starts at fptr=0; disable mid-burst
    wait_fetch("r1", BASE, 6'd4);
    send_beats(0, 2, 16);
    en = 1'b0;
    send_beats(2, 2, 16);
    step(2);
    chk("drain_empty", {63'h0, buf_valid}, 64'd0);
    chk("drain_no_req", {63'h0, fetch_req}, 64'd0);
    en = 1'b1;
    wait_fetch("r2", BASE, 6'd4);
    send_beats(0, 4, 16);
    chk("r2_bufv", {63'h0, buf_valid}, 64'd1);
    en = 1'b0;
    step(2);
    chk("flush_empty", {63'h0, buf_valid}, 64'd0);
    rdh_wr = 1'b1; rdh_wdata = 16'd5;
    step(1);
    rdh_wr = 1'b0;
    chk("rdh_load", {48'h0, rdh}, 64'd5);
    en = 1'b1;
    wait_fetch("r3", BASE + 64'h50, 6'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e1000_rx_desc_ctrl.md
# e1000_rx_desc_ctrl

Receive-descriptor engine for the E1000-compatible NIC function. It fetches receive descriptors from the host ring (RDBA/RDLEN/RDH/RDT), hands buffer addresses to the RX datapath, writes descriptor status back to host memory, and raises RXT0/RXDMT0 interrupt pulses. It sits between the register file, the PCI master DMA engine and the MAC RX datapath, and is the receive counterpart of the transmit descriptor engine.

## Interface
- FIFO_DEPTH, 8: prefetched descriptor slots (power of 2, 4..32); also the maximum fetch burst.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- en  in  1  RCTL.EN level.
- rdba  in  64  ring base, 16-byte aligned.
- rdlen  in  20  ring bytes; N = rdlen[19:4] descriptors.
- rdt  in  16  tail, host-owned.
- rdh_wr / rdh_wdata  in  1/16  head write; honoured only while en=0.
- rdmts  in  2  threshold: 0=N/2, 1=N/4, 2 or 3=N/8.
- rdh  out  16  current head.
- fetch_req / fetch_addr / fetch_cnt  out  1/64/6  read request in descriptors; fetch_ack in 1.
- fd_valid / fd_data  in  1/128  one descriptor per beat; always accepted.
- buf_valid / buf_addr  out  1/64; buf_ready in 1  buffer hand-out.
- cpl_valid / cpl_len / cpl_eop  in  1/16/1; cpl_ready out 1  packet-fragment completion.
- wb_valid / wb_addr / wb_data  out  1/64/64; wb_ready in 1  status write-back.
- intr_rxt0 / intr_rxdmt0  out  1/1  single-cycle pulses.

## Operation
- Pointers, all mod N: fptr (next fetch), head (next write-back). NIC-owned = (rdt − head) mod N; unfetched = (rdt − fptr) mod N.
- Fetch FSM IDLE→REQ→DATA→IDLE. Leave IDLE when en=1, N≠0, unfetched>0 and FIFO free ≥1. fetch_cnt = min(unfetched, FIFO free, N − fptr), so a burst never crosses the ring end. fetch_addr = rdba + fptr·16. REQ holds until fetch_ack; DATA pushes fd_data[63:0] per beat; fptr advances by fetch_cnt on the last beat.
- Buffer hand-out: buf_valid = FIFO non-empty; buf_ready pops.
- Completion/write-back FSM IDLE→WB. cpl_ready = 1 only in IDLE while a handed-out, uncompleted buffer exists. On accept: wb_addr = rdba + head·16 + 8, wb_data = {16'h0, 8'h0, status, 16'h0, cpl_len} with status DD=1, EOP=cpl_eop. On wb handshake head ← head+1 (mod N) and intr_rxt0 pulses if EOP.
- RXDMT0 pulses once per crossing, when NIC-owned falls from ≥ threshold to < threshold.
- en 1→0: an in-progress fetch burst drains (beats accepted, then discarded), FIFO is flushed, then fptr ← head. A pending write-back completes. rdh_wr while en=0 loads head and fptr.
- rdt moving backward past fptr is a host error; no protection.

## Timing
- Reset: all outputs 0; rdh=0; FIFO empty; both FSMs IDLE.
- fetch_req rises 1 cycle after the fetch condition holds; it drops the cycle after fetch_ack.
- buf_valid rises 1 cycle after the first beat of a burst is pushed.
- wb_valid rises 1 cycle after cpl accept; only one write-back outstanding.
- rdh and intr_rxt0 update in the cycle after the wb handshake.
- rdt_wr is not present; rdt is sampled every cycle.

## Configuration
- E1000_RXDMT_EN defined: RXDMT0 threshold logic is built.
- Undefined: intr_rxdmt0 is tied 0 and rdmts is ignored.

## Structure
- e1000_rx_pkg: DESC_SIZE=16, status bit positions (DD=0, EOP=1), rdmts encodings, FSM state enums.
- Sub-module rx_desc_fifo: synchronous FIFO, 64-bit wide, FIFO_DEPTH deep, with a flush input.

## Test plan
- N=8, head=0, rdt=3, en=1: exactly one fetch, fetch_cnt=3, addr=rdba. Three buffers handed out in ring order.
- N=8, fptr=6, rdt=2: two bursts, cnt=2 at rdba+0x60, then cnt=2 at rdba. No burst crosses the wrap.
- Completions len=64/EOP=0 then len=60/EOP=1: write-backs at +0x08 and +0x18 with status 0x1 and 0x3. A single intr_rxt0 pulse follows the second. rdh=2.
- N=16, rdmts=0, rdt=head+9, complete 2 buffers: intr_rxdmt0 pulses once, when NIC-owned drops 8→7. Macro off: never pulses.
- en dropped mid-burst (cnt=4, 2 beats delivered): remaining 2 beats are accepted, the FIFO empties, and fptr equals head. rdh_wr=5 then loads rdh=5.
- aresetn asserted during WB: all outputs 0 immediately. After release, the first fetch uses fptr=0.
